// File: rtl/button_bounce_emulator.sv
// Mechanical push-button emulator: turns a clean level request into a bouncing
// contact waveform with LFSR-spaced glitches, followed by a settle window.
module button_bounce_emulator #(
  parameter int unsigned TICK_DIV     = 100,
  parameter int unsigned N_BOUNCE     = 8,
  parameter int unsigned GAP_BITS     = 8,
  parameter int unsigned SETTLE_TICKS = 20000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  output logic button_out,
  output logic busy,
  output logic done
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned RW = (N_BOUNCE == 0) ? 1 : $clog2(2 * N_BOUNCE + 1);
  localparam int unsigned GW = GAP_BITS + 1;
  localparam int unsigned SW = $clog2(SETTLE_TICKS + 1);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] TAPS = 16'hB400;

  typedef enum logic [1:0] {
    STABLE = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt;
  logic [15:0]     lfsr;
  logic            press_q;
  logic            level, level_d;
  logic            target, target_d;
  logic [RW-1:0]   remaining, remaining_d;
  logic [GW-1:0]   gap, gap_d;
  logic [SW-1:0]   settle, settle_d;
  logic            out_d, busy_d, done_d;
  logic            tick;
  logic [15:0]     lfsr_nxt;
  logic [GW-1:0]   gap_next;

  assign tick     = (cnt == CW'(TICK_DIV - 1));
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
  // One extra bit keeps the +1 from wrapping to a zero-length gap.
  assign gap_next = {1'b0, lfsr[GAP_BITS-1:0]} + GW'(1);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      lfsr       <= SEED;
      press_q    <= 1'b0;
      state      <= STABLE;
      level      <= 1'b0;
      target     <= 1'b0;
      remaining  <= '0;
      gap        <= '0;
      settle     <= '0;
      button_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CW'(1);
      if (tick) lfsr <= lfsr_nxt;
      press_q    <= press;
      state      <= state_d;
      level      <= level_d;
      target     <= target_d;
      remaining  <= remaining_d;
      gap        <= gap_d;
      settle     <= settle_d;
      button_out <= out_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state;
    level_d     = level;
    target_d    = target;
    remaining_d = remaining;
    gap_d       = gap;
    settle_d    = settle;
    out_d       = button_out;
    done_d      = 1'b0;

    unique case (state)
      STABLE: begin
        out_d = level;
        if (press_q != level) begin
          out_d       = ~level;
          target_d    = press_q;
          remaining_d = RW'(2 * N_BOUNCE);
          gap_d       = gap_next;
          if (N_BOUNCE == 0) begin
            level_d  = press_q;
            settle_d = SW'(SETTLE_TICKS);
            state_d  = SETTLE;
          end else begin
            state_d = BOUNCE;
          end
        end
      end
      BOUNCE: begin
        if (tick) begin
          if (gap == GW'(1)) begin
            out_d       = ~button_out;
            remaining_d = remaining - RW'(1);
            gap_d       = gap_next;
            if (remaining == RW'(1)) begin
              level_d  = target;
              settle_d = SW'(SETTLE_TICKS);
              state_d  = SETTLE;
            end
          end else begin
            gap_d = gap - GW'(1);
          end
        end
      end
      SETTLE: begin
        if (tick) begin
          if (settle == SW'(1)) begin
            state_d = STABLE;
            done_d  = 1'b1;
          end else begin
            settle_d = settle - SW'(1);
          end
        end
      end
      default: state_d = STABLE;
    endcase

    busy_d = (state_d != STABLE);
  end

endmodule

// File: tb/tb_button_bounce_emulator.sv
// Scoreboard bench: an event-level reference model predicts every button_out edge
// and done pulse for a bouncing and a clean-edge instance driven by the same press.
module tb_button_bounce_emulator;

  localparam int TD    = 4;
  localparam int GB    = 4;
  localparam int ST    = 10;
  localparam int MAXE  = 9000;
  localparam int GMASK = (1 << GB) - 1;

  typedef struct {
    bit is_done;
    int edge_no;
    bit val;
  } ev_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       press = 1'b0;
  logic [1:0] bo, bz, dn;
  logic [1:0] prev = 2'b00;
  int         cyc  = 0;
  int         errors = 0;
  int         checks = 0;
  bit         press_at [MAXE+2];
  logic [15:0] lfsr_tab [MAXE/TD+2];
  ev_t        exq [2][$];
  int         starts [$];

  button_bounce_emulator #(
    .TICK_DIV(TD), .N_BOUNCE(3), .GAP_BITS(GB), .SETTLE_TICKS(ST), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .press(press),
    .button_out(bo[0]), .busy(bz[0]), .done(dn[0])
  );

  button_bounce_emulator #(
    .TICK_DIV(TD), .N_BOUNCE(0), .GAP_BITS(GB), .SETTLE_TICKS(ST), .LFSR_SEED(16'hACE1)
  ) dut0 (
    .clk(clk), .rst(rst), .press(press),
    .button_out(bo[1]), .busy(bz[1]), .done(dn[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Ticks fall on edges that are multiples of TD; n-th tick strictly after edge e.
  function automatic int tick_after(int e, int n);
    return (e / TD + n) * TD;
  endfunction

  function automatic void push(int d, bit is_done, int t, bit v, int lim);
    ev_t e;
    e.is_done = is_done;
    e.edge_no = t;
    e.val     = v;
    if (t <= lim) exq[d].push_back(e);
  endfunction

  function automatic void build(int d, int lim);
    int nb;
    int k;
    int t;
    int g;
    bit level;
    bit pq;
    bit v;
    nb    = (d == 0) ? 3 : 0;
    k     = 1;
    level = 1'b0;
    exq[d].delete();
    if (d == 0) starts.delete();
    while (k <= lim) begin
      pq = (k == 1) ? 1'b0 : press_at[k-1];
      if (pq == level) begin
        k++;
      end else begin
        t = k;
        v = ~level;
        if (d == 0) starts.push_back(t);
        push(d, 1'b0, t, v, lim);
        for (int i = 0; i < 2 * nb; i++) begin
          g = int'(lfsr_tab[(t - 1) / TD] & 16'(GMASK)) + 1;
          t = tick_after(t, g);
          v = ~v;
          push(d, 1'b0, t, v, lim);
        end
        t = tick_after(t, ST);
        push(d, 1'b1, t, 1'b1, lim);
        level = pq;
        k     = t + 1;
      end
    end
  endfunction

  task automatic chk(string name, int d, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0b, required %0b", name, d, got, exp);
    end
  endtask

  task automatic check_ev(int d, bit is_done, bit val);
    ev_t e;
    checks++;
    if (exq[d].size() == 0) begin
      errors++;
      $display("FAIL unexpected_event dut%0d: got done=%0d val=%0d at edge %0d, required none",
               d, is_done, val, cyc);
      return;
    end
    e = exq[d].pop_front();
    if (e.is_done != is_done || e.edge_no != cyc || e.val != val) begin
      errors++;
      $display("FAIL event dut%0d: got done=%0d edge=%0d val=%0d, required done=%0d edge=%0d val=%0d",
               d, is_done, cyc, val, e.is_done, e.edge_no, e.val);
    end
  endtask

  // Monitor: every observed toggle or done pulse is matched against the queue head.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (bo[d] != prev[d]) begin
          check_ev(d, 1'b0, bo[d]);
          chk("busy_on_toggle", d, bz[d], 1'b1);
        end
        if (dn[d]) begin
          check_ev(d, 1'b1, 1'b1);
          chk("busy_at_done", d, bz[d], 1'b0);
        end
      end
    end
    prev <= bo;
  end

  task automatic run(int lim, bit debounce);
    int rises;
    bit s0;
    bit s1;
    bit db;
    rises = 0;
    s0 = 1'b0;
    s1 = 1'b0;
    db = 1'b0;
    rst   = 1'b1;
    press = press_at[1];
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_button_out", d, bo[d], 1'b0);
      chk("reset_busy", d, bz[d], 1'b0);
      chk("reset_done", d, dn[d], 1'b0);
    end
    build(0, lim);
    build(1, lim);
    rst = 1'b0;
    for (int k = 1; k <= lim; k++) begin
      press = press_at[k];
      @(posedge clk);
      @(negedge clk);
      if (debounce && (k % 512) == 0) begin
        s1 = s0;
        s0 = bo[0];
        if (s0 == s1 && s0 != db) begin
          db = s0;
          if (db) rises++;
        end
      end
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("abort_button_out", d, bo[d], 1'b0);
      chk("abort_busy", d, bz[d], 1'b0);
      checks++;
      if (exq[d].size() != 0) begin
        errors++;
        $display("FAIL missing_events dut%0d: got %0d unseen, required 0 (next edge %0d)",
                 d, exq[d].size(), exq[d][0].edge_no);
      end
    end
    if (debounce) begin
      checks++;
      if (rises != 1) begin
        errors++;
        $display("FAIL debounced_pulses: got %0d, required 1", rises);
      end
      chk("debounced_final", 0, db, 1'b0);
    end
  endtask

  initial begin
    int k;
    int len;
    int cut;
    bit lv;
    logic [15:0] l;

    lfsr_tab[0] = 16'hACE1;
    for (int i = 1; i < MAXE / TD + 2; i++) begin
      l = lfsr_tab[i-1];
      lfsr_tab[i] = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    end

    // Clean press held through reset, then release; debouncer loopback on dut.
    for (int i = 0; i < MAXE + 2; i++) press_at[i] = (i >= 1 && i <= 2500);
    run(5000, 1'b1);

    // Random press pattern: long holds mixed with short glitches during sequences.
    k  = 1;
    lv = 1'b0;
    press_at[0] = 1'b0;
    while (k <= MAXE + 1) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(20, 700));
      lv  = ~lv;
      for (int j = 0; j < len && k <= MAXE + 1; j++) begin
        press_at[k] = lv;
        k++;
      end
    end
    run(8000, 1'b0);

    // Abort one edge after a sequence's first toggle, then replay the full pattern.
    build(0, 8000);
    if (starts.size() > 2) cut = starts[2] + 1;
    else if (starts.size() > 0) cut = starts[0] + 1;
    else cut = 100;
    run(cut, 1'b0);
    run(8000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
